serv_lsu_w: RTL and testbench
=============================

Name: serv_lsu_w

Overview:
Parametrised load/store unit for the bit/nibble-serial SERV core, with a serial datapath of W bits per cycle.
- Store: accepts store data serially, aligns it and runs a Wishbone write.
- Load: runs a Wishbone read, then aligns, masks and sign-extends the data and returns it serially.
- Optionally splits word-crossing (misaligned) accesses into two bus cycles instead of trapping.
- Sits between the core's decode/state logic and the data-bus arbiter.

Parameters:
W, 1, serial width in bits per beat; legal values 1, 2, 4, 8; N = 32/W beats per word.
WITH_MISALIGN, 1, 1: split word-crossing accesses into two bus cycles; 0: reject them via o_misalign.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  one-cycle request pulse; sampled only in IDLE
i_we  in  1  1 = store, 0 = load (sampled with i_start)
i_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word (sampled with i_start)
i_signed  in  1  sign-extend load result (sampled with i_start)
i_adr  in  32  byte address (sampled with i_start)
i_en  in  1  beat strobe for serial fill/drain
i_op_b  in  W  store data beat, LSB-first
o_rd  out  W  load result beat, LSB-first
o_rd_valid  out  1  o_rd valid (DRAIN state)
o_busy  out  1  not IDLE
o_done  out  1  one-cycle completion pulse
o_misalign  out  1  one-cycle reject pulse (WITH_MISALIGN=0 only)
o_wb_adr  out  30  word address [31:2]
o_wb_dat  out  32  write data
o_wb_sel  out  4  byte enables
o_wb_we  out  1  write enable
o_wb_cyc  out  1  bus request
i_wb_rdt  in  32  read data
i_wb_ack  in  1  bus acknowledge

Behaviour:
- Reset (asynchronous, takes effect immediately): state IDLE, beat counter 0, data registers 0. All outputs are 0, including o_wb_cyc, which drops immediately even mid-cycle.
- Request decode (latched at i_start): lsb = i_adr[1:0], bytes = 1/2/4 from i_size, cross = (lsb + bytes > 4).
- State IDLE:
  - i_start & cross & !WITH_MISALIGN -> o_misalign=1 and o_done=1 in the next cycle, no bus cycle, stay IDLE.
  - else i_start & i_we -> FILL.
  - else i_start -> BUS1.
- State FILL:
  - Each cycle with i_en=1 shifts i_op_b into a 32-bit register from the top (first beat ends in bits [W-1:0]) and increments the beat counter.
  - On beat N-1 -> BUS1; counter wraps to 0.
  - Cycles with i_en=0 hold the register and counter.
- Alignment: store data is placed in a 64-bit lane as {32'b0, data} << (8*lsb).
- State BUS1:
  - o_wb_cyc=1, o_wb_adr = i_adr[31:2], o_wb_we = i_we, o_wb_dat = lane[31:0].
  - o_wb_sel = ((1<<bytes)-1) << lsb, bits [3:0].
  - Outputs are stable until i_wb_ack. On ack, i_wb_rdt is captured as rdt_lo.
  - Next state: BUS2 if cross, else DRAIN for a load, else IDLE with o_done=1 for a store.
  - o_wb_cyc is 0 in the cycle after an ack.
- State BUS2:
  - o_wb_adr = i_adr[31:2] + 1 (wraps mod 2^30), o_wb_dat = lane[63:32], o_wb_sel = mask bits [7:4].
  - On ack, i_wb_rdt is captured as rdt_hi.
  - Next state: DRAIN for a load; IDLE with o_done=1 for a store.
- Load result: r = ({rdt_hi, rdt_lo} >> 8*lsb)[31:0]. Bits at or above 8*bytes are replaced with (i_signed & the sign bit at 8*bytes-1), else 0. rdt_hi is 0 when not cross.
- State DRAIN:
  - o_rd_valid=1, o_rd = r[W-1:0] of the shifting result register.
  - Each i_en=1 cycle shifts right by W and increments the counter.
  - On beat N-1 with i_en=1: o_done=1 in that same cycle (combinational), then IDLE.
  - o_rd_valid=0 outside DRAIN.
- o_busy = (state != IDLE).
- Ignored inputs: i_start when not IDLE; i_wb_ack outside BUS1/BUS2; i_en outside FILL/DRAIN.
- o_done and o_misalign never assert in the same cycle except on a reject, where both are 1.

Test Plan:
1. W=1, load word at 0x100, rdt 0xDEADBEEF, ack after 3 cycles -> o_wb_sel=1111, o_wb_adr=0x40, o_wb_we=0. 32 drain beats reproduce 0xDEADBEEF LSB-first; o_done on beat 31.
2. W=4, signed byte load at 0x203, rdt 0x80FFFFFF -> sel=1000, result 0xFFFFFF80. The same access unsigned -> 0x00000080.
3. W=4, store half 0xA5A51234 at 0x006 -> 8 fill beats, sel=1100, o_wb_dat=0x12340000, o_wb_we=1, o_done one cycle after ack.
4. WITH_MISALIGN=1, load word at 0x1FE, rdt 0x33221100 then 0x77665544:
   - BUS1 adr 0x7F sel=1100; BUS2 adr 0x80 sel=0011.
   - Result 0x55443322.
5. WITH_MISALIGN=0, half load at 0x3 -> o_misalign=1 and o_done=1 for one cycle, o_wb_cyc stays 0.
6. Reset and stray inputs:
   - Deassert i_rst_n mid-BUS1 -> o_wb_cyc drops asynchronously and the block returns to IDLE.
   - i_start during DRAIN and a stray i_wb_ack in IDLE -> no effect.

Source files
------------

// File: rtl/serv_lsu_w.sv
// serv_lsu_w: load/store unit for the serial SERV core, W bits per beat.
//   Stores: collect N=32/W beats of i_op_b, align the word into the byte
//   lanes and run one Wishbone write (two if the access crosses a word).
//   Loads: run one or two Wishbone reads, then align, mask and sign-extend
//   the data and return it as N beats on o_rd.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_start/i_we/i_size/
//   i_signed/i_adr            request, sampled only in IDLE
//   i_en, i_op_b              beat strobe and store data beat (LSB-first)
//   o_rd, o_rd_valid          load result beat (LSB-first), valid in DRAIN
//   o_busy, o_done,
//   o_misalign                status; o_misalign rejects a word-crossing
//                             access when WITH_MISALIGN=0
//   o_wb_*, i_wb_rdt, i_wb_ack  Wishbone data-bus master
module serv_lsu_w #(
  parameter int W             = 1,
  parameter bit WITH_MISALIGN = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_we,
  input  logic [1:0]    i_size,
  input  logic          i_signed,
  input  logic [31:0]   i_adr,
  input  logic          i_en,
  input  logic [W-1:0]  i_op_b,
  output logic [W-1:0]  o_rd,
  output logic          o_rd_valid,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_misalign,
  output logic [29:0]   o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack
);

  localparam int N  = 32 / W;
  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {IDLE, FILL, BUS1, BUS2, DRAIN} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   dat_q;     // store data while filling, load result while draining
  logic [31:0]   rdt_lo_q;
  logic [31:0]   adr_q;
  logic [2:0]    bytes_q;
  logic          we_q, signed_q, cross_q;
  logic          cyc_q, done_q, mis_q;

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  logic [2:0]  in_end;
  logic        in_cross;
  logic        last, ack_ok, in_bus, bus2;
  logic [7:0]  mask8;
  logic [63:0] lane;
  logic [63:0] raw;
  logic [31:0] shifted, load_res;

  assign in_end   = {1'b0, i_adr[1:0]} + size_bytes(i_size);
  assign in_cross = in_end > 3'd4;
  assign last     = cnt_q == CW'(N - 1);
  // An ack only counts while the request is actually on the bus.
  assign ack_ok   = cyc_q & i_wb_ack;
  assign bus2     = state_q == BUS2;
  assign in_bus   = (state_q == BUS1) | bus2;
  assign mask8    = ((8'd1 << bytes_q) - 8'd1) << adr_q[1:0];
  assign lane     = {32'd0, dat_q} << {adr_q[1:0], 3'b000};

  // The high word is never registered: in BUS2 it is consumed straight from
  // the bus together with the low word captured in BUS1.
  always_comb begin
    raw      = bus2 ? {i_wb_rdt, rdt_lo_q} : {32'd0, i_wb_rdt};
    shifted  = 32'(raw >> {adr_q[1:0], 3'b000});
    load_res = shifted;
    if (bytes_q == 3'd1)      load_res[31:8]  = {24{signed_q & shifted[7]}};
    else if (bytes_q == 3'd2) load_res[31:16] = {16{signed_q & shifted[15]}};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dat_q    <= '0;
      rdt_lo_q <= '0;
      adr_q    <= '0;
      bytes_q  <= '0;
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      cross_q  <= 1'b0;
      cyc_q    <= 1'b0;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      case (state_q)
        IDLE: if (i_start) begin
          adr_q    <= i_adr;
          we_q     <= i_we;
          bytes_q  <= size_bytes(i_size);
          signed_q <= i_signed;
          cross_q  <= in_cross;
          if (in_cross && !WITH_MISALIGN) begin
            done_q <= 1'b1;
            mis_q  <= 1'b1;
          end else if (i_we) begin
            state_q <= FILL;
          end else begin
            state_q <= BUS1;
            cyc_q   <= 1'b1;
            dat_q   <= '0;
          end
        end
        FILL: if (i_en) begin
          // Shift in from the top so the first beat lands in the LSBs.
          dat_q <= {i_op_b, dat_q[31:W]};
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            cnt_q   <= '0;
            state_q <= BUS1;
            cyc_q   <= 1'b1;
          end
        end
        BUS1: if (ack_ok) begin
          rdt_lo_q <= i_wb_rdt;
          cyc_q    <= 1'b0;
          if (cross_q) begin
            state_q <= BUS2;
          end else if (we_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            dat_q   <= load_res;
            state_q <= DRAIN;
          end
        end
        BUS2: begin
          // First BUS2 cycle is the one-cycle gap with cyc low after the
          // BUS1 ack; the second access is raised on the next cycle.
          if (ack_ok) begin
            cyc_q <= 1'b0;
            if (we_q) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              dat_q   <= load_res;
              state_q <= DRAIN;
            end
          end else begin
            cyc_q <= 1'b1;
          end
        end
        DRAIN: if (i_en) begin
          dat_q <= dat_q >> W;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy     = state_q != IDLE;
  assign o_rd_valid = state_q == DRAIN;
  assign o_rd       = o_rd_valid ? dat_q[W-1:0] : '0;
  assign o_done     = done_q | (o_rd_valid & i_en & last);
  assign o_misalign = mis_q;
  assign o_wb_cyc   = cyc_q;
  assign o_wb_we    = in_bus & we_q;
  assign o_wb_adr   = !in_bus ? '0 : bus2 ? adr_q[31:2] + 30'd1 : adr_q[31:2];
  assign o_wb_dat   = !in_bus ? '0 : bus2 ? lane[63:32] : lane[31:0];
  assign o_wb_sel   = !in_bus ? '0 : bus2 ? mask8[7:4] : mask8[3:0];

endmodule

// File: tb/tb_serv_lsu_w.sv
// Scoreboard bench for serv_lsu_w. Two instances: u0 (W=4, split crossing
// accesses) and u1 (W=1, reject crossing accesses). A byte-addressed memory
// model predicts bus cycles, load results and completion pulses; monitors
// compare them against what each instance presents.
module tb_serv_lsu_w;
  localparam logic [1:0] EV_BUS = 2'd0, EV_RES = 2'd1, EV_DONE = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [29:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
    logic        mis;
  } ev_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start [2], we [2], sgn [2], en [2], ack [2], stray [2], hold [2];
  logic [1:0]  size [2];
  logic [31:0] adr [2], rdt [2];
  logic [7:0]  opb [2];
  wire  [3:0]  rd0;
  wire  [0:0]  rd1;
  wire         rdv [2], busy [2], done [2], mis [2], wbwe [2], cyc [2];
  wire  [29:0] wadr [2];
  wire  [31:0] wdat [2];
  wire  [3:0]  wsel [2];

  int checks = 0, failures = 0;
  ev_t q0[$], q1[$];
  logic [31:0] bmem [bit [30:0]];   // bus-side memory, written by DUT stores
  logic [31:0] rmem [bit [30:0]];   // reference memory, written by the model

  always #5 clk = ~clk;

  serv_lsu_w #(.W(4), .WITH_MISALIGN(1'b1)) u0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_we(we[0]),
    .i_size(size[0]), .i_signed(sgn[0]), .i_adr(adr[0]), .i_en(en[0]),
    .i_op_b(opb[0][3:0]), .o_rd(rd0), .o_rd_valid(rdv[0]), .o_busy(busy[0]),
    .o_done(done[0]), .o_misalign(mis[0]), .o_wb_adr(wadr[0]),
    .o_wb_dat(wdat[0]), .o_wb_sel(wsel[0]), .o_wb_we(wbwe[0]),
    .o_wb_cyc(cyc[0]), .i_wb_rdt(rdt[0]), .i_wb_ack(ack[0] | stray[0]));

  serv_lsu_w #(.W(1), .WITH_MISALIGN(1'b0)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_we(we[1]),
    .i_size(size[1]), .i_signed(sgn[1]), .i_adr(adr[1]), .i_en(en[1]),
    .i_op_b(opb[1][0:0]), .o_rd(rd1), .o_rd_valid(rdv[1]), .o_busy(busy[1]),
    .o_done(done[1]), .o_misalign(mis[1]), .o_wb_adr(wadr[1]),
    .o_wb_dat(wdat[1]), .o_wb_sel(wsel[1]), .o_wb_we(wbwe[1]),
    .o_wb_cyc(cyc[1]), .i_wb_rdt(rdt[1]), .i_wb_ack(ack[1] | stray[1]));

  function automatic logic [7:0] rdw(input int k);
    return (k == 0) ? {4'b0, rd0} : {7'b0, rd1};
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction
  function automatic ev_t qpop(input int k);
    return (k == 0) ? q0.pop_front() : q1.pop_front();
  endfunction
  function automatic void qpush(input int k, input ev_t e);
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  function automatic logic [31:0] init_word(input bit [30:0] key);
    return ({1'b0, key} * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction
  function automatic logic [31:0] bus_word(input bit [30:0] key);
    return bmem.exists(key) ? bmem[key] : init_word(key);
  endfunction
  function automatic logic [31:0] ref_word(input bit [30:0] key);
    return rmem.exists(key) ? rmem[key] : init_word(key);
  endfunction
  function automatic logic [7:0] ref_rd_byte(input int k, input logic [31:0] a);
    logic [31:0] w;
    w = ref_word({k[0], a[31:2]});
    return w[{a[1:0], 3'b000} +: 8];
  endfunction
  function automatic void ref_wr_byte(input int k, input logic [31:0] a, input logic [7:0] b);
    logic [31:0] w;
    w = ref_word({k[0], a[31:2]});
    w[{a[1:0], 3'b000} +: 8] = b;
    rmem[{k[0], a[31:2]}] = w;
  endfunction
  function automatic void preload(input int k, input logic [29:0] wa, input logic [31:0] v);
    bmem[{k[0], wa}] = v;
    rmem[{k[0], wa}] = v;
  endfunction

  // Wishbone slave for both instances: random wait states, reads from bmem,
  // applies byte-enabled writes to bmem.
  initial begin
    int dly [2];
    bit [30:0] key;
    logic [31:0] w;
    dly[0] = 1; dly[1] = 3;
    ack[0] = 1'b0; ack[1] = 1'b0; rdt[0] = '0; rdt[1] = '0;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (!rst_n || ack[k]) begin
          ack[k] = 1'b0;
        end else if (cyc[k] && !hold[k]) begin
          if (dly[k] == 0) begin
            key = {k[0], wadr[k]};
            w = bus_word(key);
            rdt[k] = w;
            if (wbwe[k]) begin
              for (int j = 0; j < 4; j++)
                if (wsel[k][j]) w[j*8 +: 8] = wdat[k][j*8 +: 8];
              bmem[key] = w;
            end
            ack[k] = 1'b1;
            dly[k] = $urandom_range(0, 3);
          end else begin
            dly[k]--;
          end
        end
      end
    end
  end

  task automatic unexpected(input string nm, input int k);
    checks++;
    failures++;
    $display("FAIL unexpected_%s inst%0d: event seen with no expectation queued", nm, k);
  endtask

  task automatic monitor(input int k, input int w);
    logic [31:0] acc = '0;
    int nb = 0;
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin nb = 0; continue; end
      if (cyc[k] && (ack[k] || stray[k])) begin
        if (qsize(k) == 0) unexpected("bus", k);
        else begin
          e = qpop(k);
          chk("ev_order_bus", k, 64'(EV_BUS), 64'(e.kind));
          chk("wb_adr", k, wadr[k], e.adr);
          chk("wb_sel", k, wsel[k], e.sel);
          chk("wb_we", k, wbwe[k], e.we);
          if (e.we) chk("wb_dat", k, wdat[k], e.dat);
        end
      end
      if (rdv[k] && en[k]) begin
        acc = (acc >> w) | ({24'b0, rdw(k)} << (32 - w));
        nb++;
        if (nb == 32 / w) begin
          nb = 0;
          if (qsize(k) == 0) unexpected("result", k);
          else begin
            e = qpop(k);
            chk("ev_order_res", k, 64'(EV_RES), 64'(e.kind));
            chk("load_result", k, acc, e.dat);
          end
        end
      end
      if (done[k] || mis[k]) begin
        if (qsize(k) == 0) unexpected("done", k);
        else begin
          e = qpop(k);
          chk("ev_order_done", k, 64'(EV_DONE), 64'(e.kind));
          chk("done_pulse", k, done[k], 1);
          chk("misalign", k, mis[k], e.mis);
        end
      end
    end
  endtask

  initial fork
    monitor(0, 4);
    monitor(1, 1);
  join

  // Reference model: byte-level memory semantics; then drive the request.
  task automatic txn(input int k, input logic w_e, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] d);
    int w, n, nbytes, lsb, nb, cnt;
    bit crs, reject;
    logic [3:0] s1, s2;
    logic [31:0] b, r, tmp;
    logic [63:0] lane;
    ev_t e;
    w = (k == 0) ? 4 : 1;
    n = 32 / w;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lsb = int'(a[1:0]);
    crs = (lsb + nbytes) > 4;
    reject = crs && (k == 1);
    if (reject) begin
      e = '0; e.kind = EV_DONE; e.mis = 1'b1; qpush(k, e);
    end else begin
      s1 = '0; s2 = '0;
      for (int i = 0; i < nbytes; i++) begin
        b = a + 32'(i);
        if (b[31:2] == a[31:2]) s1[b[1:0]] = 1'b1; else s2[b[1:0]] = 1'b1;
      end
      lane = {32'd0, d} << (8 * lsb);
      e = '0; e.kind = EV_BUS; e.adr = a[31:2]; e.sel = s1; e.we = w_e; e.dat = lane[31:0];
      qpush(k, e);
      if (crs) begin
        e.adr = a[31:2] + 30'd1; e.sel = s2; e.dat = lane[63:32];
        qpush(k, e);
      end
      if (w_e) begin
        for (int i = 0; i < nbytes; i++) ref_wr_byte(k, a + 32'(i), d[i*8 +: 8]);
      end else begin
        r = '0;
        for (int i = 0; i < nbytes; i++) r = r | ({24'b0, ref_rd_byte(k, a + 32'(i))} << (8 * i));
        if (sg && nbytes < 4 && r[8*nbytes-1]) r = r | (32'hFFFFFFFF << (8 * nbytes));
        e = '0; e.kind = EV_RES; e.dat = r; qpush(k, e);
      end
      e = '0; e.kind = EV_DONE; qpush(k, e);
    end

    @(posedge clk); #1;
    start[k] = 1'b1; we[k] = w_e; size[k] = sz; sgn[k] = sg; adr[k] = a;
    @(posedge clk); #1;
    start[k] = 1'b0;
    if (w_e && !reject) begin
      nb = 0;
      while (nb < n) begin
        en[k] = ($urandom_range(0, 3) != 0);
        if (en[k]) begin
          tmp = d >> (w * nb);
          opb[k] = tmp[7:0] & ((8'd1 << w) - 8'd1);
          nb++;
        end
        @(posedge clk); #1;
      end
    end
    cnt = 0;
    while (!(qsize(k) == 0 && !busy[k])) begin
      if (++cnt > 3000) begin
        checks++;
        failures++;
        $display("FAIL txn_timeout inst%0d: busy=%0b pending=%0d, required idle with nothing pending",
                 k, busy[k], qsize(k));
        if (k == 0) q0.delete(); else q1.delete();
        break;
      end
      en[k] = ($urandom_range(0, 3) != 0);
      // Stray requests while draining must be ignored.
      if (rdv[k] && $urandom_range(0, 7) == 0) begin
        start[k] = 1'b1; adr[k] = $urandom; we[k] = 1'($urandom); size[k] = 2'($urandom);
      end else begin
        start[k] = 1'b0;
      end
      @(posedge clk); #1;
    end
    start[k] = 1'b0;
    en[k] = 1'b0;
  endtask

  task automatic rand_txn(input int k);
    logic [31:0] a;
    a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                    : 32'($urandom_range(0, 47));
    txn(k, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; we[k] = 1'b0; sgn[k] = 1'b0; en[k] = 1'b0; stray[k] = 1'b0;
      hold[k] = 1'b0; size[k] = '0; adr[k] = '0; opb[k] = '0;
    end
    rst_n = 1'b0;
    #12;
    for (int k = 0; k < 2; k++) begin
      chk("reset_status", k, {cyc[k], busy[k], done[k], mis[k], rdv[k]}, 0);
      chk("reset_wb_ctl", k, {wbwe[k], wsel[k], wadr[k]}, 0);
      chk("reset_wb_dat", k, wdat[k], 0);
      chk("reset_rd", k, rdw(k), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Stray ack while idle
    @(posedge clk); #1;
    stray[0] = 1'b1; stray[1] = 1'b1;
    @(posedge clk); #1;
    stray[0] = 1'b0; stray[1] = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) chk("stray_ack_idle", k, {busy[k], cyc[k]}, 0);

    // W=1, reject on crossing
    preload(1, 30'h40, 32'hDEADBEEF);
    txn(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    txn(1, 1'b0, 2'd1, 1'b0, 32'h3, 32'h0);
    txn(1, 1'b1, 2'd2, 1'b0, 32'h2, 32'h12345678);
    for (int n = 0; n < 40; n++) rand_txn(1);

    // W=4, split on crossing
    preload(0, 30'h80, 32'h80FFFFFF);
    txn(0, 1'b0, 2'd0, 1'b1, 32'h203, 32'h0);
    txn(0, 1'b0, 2'd0, 1'b0, 32'h203, 32'h0);
    txn(0, 1'b1, 2'd1, 1'b0, 32'h006, 32'hA5A51234);
    txn(0, 1'b0, 2'd1, 1'b1, 32'h006, 32'h0);
    preload(0, 30'h7F, 32'h33221100);
    preload(0, 30'h80, 32'h77665544);
    txn(0, 1'b0, 2'd2, 1'b0, 32'h1FE, 32'h0);
    txn(0, 1'b1, 2'd2, 1'b0, 32'hFFFFFFFE, 32'hCAFEF00D);
    txn(0, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0);
    for (int n = 0; n < 80; n++) rand_txn(0);

    // Asynchronous reset in the middle of a bus cycle
    hold[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b1; we[0] = 1'b0; size[0] = 2'd2; adr[0] = 32'h10;
    @(posedge clk); #1;
    start[0] = 1'b0;
    i = 0;
    while (!cyc[0] && i < 10) begin @(posedge clk); #1; i++; end
    chk("cyc_before_reset", 0, cyc[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_cyc", 0, cyc[0], 0);
    chk("async_reset_busy", 0, busy[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    hold[0] = 1'b0;
    txn(0, 1'b0, 2'd2, 1'b0, 32'h1FE, 32'h0);

    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk("queue_drained", k, qsize(k), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
